// File: rtl/map_scroll_ctl_pkg.sv
// Shared map-scroll definitions: map geometry, scroll FSM states and the
// saturating offset move used by the scroll controller.
package map_scroll_ctl_pkg;

   localparam int MAP_COLS     = 512;
   localparam int MAP_VIS_COLS = 256;
   localparam int MAP_OFS_W    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_L = 2'd1,
      MOVE_R = 2'd2
   } scroll_state_t;

   // Move ofs by step in direction dir, clamping to [0, max_ofs].
   // Two bits of headroom so ofs+step past 255 cannot wrap before the clamp.
   function automatic logic [MAP_OFS_W-1:0] sat_move(
      input logic [MAP_OFS_W-1:0] ofs,
      input logic [2:0]           step,
      input scroll_state_t        dir,
      input logic [MAP_OFS_W-1:0] max_ofs
   );
      logic signed [MAP_OFS_W+1:0] sum;
      logic signed [MAP_OFS_W+1:0] stp;
      logic signed [MAP_OFS_W+1:0] lim;
      sum = $signed({2'b00, ofs});
      stp = $signed({7'd0, step});
      lim = $signed({2'b00, max_ofs});
      case (dir)
         MOVE_L:  sum = sum - stp;
         MOVE_R:  sum = sum + stp;
         default: sum = sum;
      endcase
      if (sum < 0)
         return '0;
      else if (sum > lim)
         return max_ofs;
      else
         return sum[MAP_OFS_W-1:0];
   endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bus; the scroll controller only looks at vblnk.
interface vga_if;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vsync;
   logic        vblnk;
   logic        hsync;
   logic        hblnk;

   modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk);
   modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk);
endinterface

// File: rtl/edge_rise.sv
// Registered 1-bit rising-edge detector: pulse_o is high for one cycle in
// the cycle after the edge that first sees d_i high.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic pulse_o
);

   logic d_q;
   logic pulse_q;

   // history of d_i and the registered rise pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q     <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         d_q     <= d_i;
         pulse_q <= d_i & ~d_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/map_scroll_ctl.sv
// Horizontal map offset controller: one offset update per FRAME_DIV frames,
// applied at the start of vblank, with step acceleration and edge clamping.
module map_scroll_ctl
   import map_scroll_ctl_pkg::*;
#(
   parameter int FRAME_DIV = 2,
   parameter int MAX_STEP  = 4,
   parameter int MAX_OFS   = 255,
   parameter int START_OFS = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   vga_if.in                    in,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 scroll_en,
   output logic [MAP_OFS_W-1:0] map_ofset,
   output logic                 at_left,
   output logic                 at_right,
   output logic                 frame_tick
);

   localparam logic [3:0]           DIV_LAST  = 4'(FRAME_DIV - 1);
   localparam logic [2:0]           STEP_MAX  = 3'(MAX_STEP);
   localparam logic [MAP_OFS_W-1:0] OFS_MAX   = MAP_OFS_W'(MAX_OFS);
   localparam logic [MAP_OFS_W-1:0] OFS_START = MAP_OFS_W'(START_OFS);

   logic [3:0]           cnt_q, cnt_d;
   scroll_state_t        state_q, state_d;
   logic [2:0]           step_q, step_d;
   logic [MAP_OFS_W-1:0] ofs_q, ofs_d;
   logic                 at_left_q, at_left_d;
   logic                 at_right_q, at_right_d;
   logic                 strobe;
   scroll_state_t        dir;

   edge_rise u_vblnk_rise (
      .clk     (clk),
      .rst     (rst),
      .d_i     (in.vblnk),
      .pulse_o (frame_tick)
   );

   assign strobe = frame_tick & scroll_en & (cnt_q == DIV_LAST);

   // frame divider: counts enabled ticks, wraps on the update frame
   always_comb begin
      cnt_d = cnt_q;
      if (frame_tick && scroll_en)
         cnt_d = (cnt_q == DIV_LAST) ? 4'd0 : cnt_q + 4'd1;
   end

   // direction decode, step acceleration and clamped offset update
   always_comb begin
      dir        = IDLE;
      state_d    = state_q;
      step_d     = step_q;
      ofs_d      = ofs_q;
      at_left_d  = at_left_q;
      at_right_d = at_right_q;
      if (strobe) begin
         case ({btn_left, btn_right})
            2'b10:   dir = MOVE_L;
            2'b01:   dir = MOVE_R;
            default: dir = IDLE;
         endcase
         if (dir != IDLE && dir == state_q)
            step_d = (step_q >= STEP_MAX) ? STEP_MAX : step_q + 3'd1;
         else
            step_d = 3'd1;
         state_d    = dir;
         ofs_d      = sat_move(ofs_q, step_d, dir, OFS_MAX);
         at_left_d  = (ofs_d == '0);
         at_right_d = (ofs_d == OFS_MAX);
      end
   end

   // controller state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= 4'd0;
         state_q    <= IDLE;
         step_q     <= 3'd1;
         ofs_q      <= OFS_START;
         at_left_q  <= (OFS_START == '0);
         at_right_q <= (OFS_START == OFS_MAX);
      end else begin
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         step_q     <= step_d;
         ofs_q      <= ofs_d;
         at_left_q  <= at_left_d;
         at_right_q <= at_right_d;
      end
   end

   assign map_ofset = ofs_q;
   assign at_left   = at_left_q;
   assign at_right  = at_right_q;

endmodule

// File: tb/tb_map_scroll_ctl.sv
// Bench for map_scroll_ctl: two instances (divide-by-1 from 0, divide-by-3
// from 100) share stimulus and are checked against a per-frame model.
module tb_map_scroll_ctl;

   localparam int MAXS   = 4;
   localparam int MAXO   = 255;
   localparam int FD[2]  = '{1, 3};
   localparam int ST[2]  = '{0, 100};

   logic            clk = 1'b0;
   logic            rst;
   logic            btn_left, btn_right, scroll_en;
   logic [1:0][7:0] ofs;
   logic [1:0]      al, ar, tk;

   int nvec = 0;
   int errs = 0;

   // frame-level model state: offset, step, direction (-1/0/+1), frame count
   int m_ofs[2], m_step[2], m_dir[2], m_cnt[2];

   vga_if vif ();

   always #5 clk = ~clk;

   map_scroll_ctl #(.FRAME_DIV(1), .MAX_STEP(MAXS), .MAX_OFS(MAXO), .START_OFS(0)) dut (
      .clk(clk), .rst(rst), .in(vif), .btn_left(btn_left), .btn_right(btn_right),
      .scroll_en(scroll_en), .map_ofset(ofs[0]), .at_left(al[0]), .at_right(ar[0]),
      .frame_tick(tk[0]));

   map_scroll_ctl #(.FRAME_DIV(3), .MAX_STEP(MAXS), .MAX_OFS(MAXO), .START_OFS(100)) dut3 (
      .clk(clk), .rst(rst), .in(vif), .btn_left(btn_left), .btn_right(btn_right),
      .scroll_en(scroll_en), .map_ofset(ofs[1]), .at_left(al[1]), .at_right(ar[1]),
      .frame_tick(tk[1]));

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ofs[i] = ST[i]; m_step[i] = 1; m_dir[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_frame(input bit l, input bit r, input bit en);
      int d, o;
      if (!en) return;
      d = (l && !r) ? -1 : (r && !l) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]++;
         if (m_cnt[i] >= FD[i]) begin
            m_cnt[i] = 0;
            if (d != 0 && d == m_dir[i]) m_step[i] = (m_step[i] < MAXS) ? m_step[i] + 1 : MAXS;
            else m_step[i] = 1;
            m_dir[i] = d;
            o = m_ofs[i] + d * m_step[i];
            m_ofs[i] = (o < 0) ? 0 : (o > MAXO) ? MAXO : o;
         end
      end
   endtask

   // one rst cycle; checks the reset values one edge later
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; vif.vblnk = 1'b0;
      @(negedge clk);
      model_reset();
      for (int i = 0; i < 2; i++) begin
         nvec++;
         if (ofs[i] !== 8'(ST[i]) || al[i] !== (ST[i] == 0) || ar[i] !== (ST[i] == MAXO) || tk[i] !== 1'b0) begin
            errs++;
            $display("FAIL reset[%0d]: ofs=%0d al=%b ar=%b tk=%b, want ofs=%0d al=%b ar=%b tk=0",
                     i, ofs[i], al[i], ar[i], tk[i], ST[i], ST[i] == 0, ST[i] == MAXO);
         end
      end
      rst = 1'b0;
   endtask

   // one frame: vblnk high 3 cycles then low 3; tick and offset checked each cycle
   task automatic do_frame(input bit l, input bit r, input bit en);
      int old[2];
      int e;
      @(negedge clk);
      btn_left = l; btn_right = r; scroll_en = en;
      vif.vblnk = 1'b1;
      old = m_ofs;
      model_frame(l, r, en);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            e = (c == 1) ? old[i] : m_ofs[i];
            nvec++;
            if (tk[i] !== (c == 1)) begin
               errs++;
               $display("FAIL frame_tick[%0d] cyc%0d: got %b want %b", i, c, tk[i], c == 1);
            end
            nvec++;
            if (ofs[i] !== 8'(e) || al[i] !== (e == 0) || ar[i] !== (e == MAXO)) begin
               errs++;
               $display("FAIL ofs[%0d] cyc%0d: got %0d al=%b ar=%b want %0d al=%b ar=%b",
                        i, c, ofs[i], al[i], ar[i], e, e == 0, e == MAXO);
            end
         end
         if (c == 3) vif.vblnk = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      repeat (3) do_frame(0, 0, 1);
      nvec++;
      if (ofs[0] !== 8'd0 || al[0] !== 1'b1 || ar[0] !== 1'b0) begin
         errs++;
         $display("FAIL idle_frames: ofs=%0d al=%b ar=%b want 0 1 0", ofs[0], al[0], ar[0]);
      end
   endtask

   task automatic test_step_seq();
      int tbl[6] = '{1, 3, 6, 10, 14, 18};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         do_frame(0, 1, 1);
         nvec++;
         if (ofs[0] !== 8'(tbl[k])) begin
            errs++;
            $display("FAIL step_seq frame%0d: got %0d want %0d", k + 1, ofs[0], tbl[k]);
         end
      end
   endtask

   task automatic test_right_edge();
      for (int k = 0; k < 80 && m_ofs[0] != MAXO; k++) do_frame(0, 1, 1);
      do_frame(0, 1, 1);
      nvec++;
      if (ofs[0] !== 8'd255 || ar[0] !== 1'b1) begin
         errs++;
         $display("FAIL right_clamp: ofs=%0d ar=%b want 255 1", ofs[0], ar[0]);
      end
      do_frame(1, 0, 1);
      nvec++;
      if (ofs[0] !== 8'd254 || ar[0] !== 1'b0) begin
         errs++;
         $display("FAIL reverse_edge: ofs=%0d ar=%b want 254 0", ofs[0], ar[0]);
      end
      do_frame(1, 0, 1);
      nvec++;
      if (ofs[0] !== 8'd252) begin
         errs++;
         $display("FAIL reverse_step2: got %0d want 252", ofs[0]);
      end
   endtask

   task automatic test_div3();
      int tbl[6] = '{100, 100, 99, 99, 99, 97};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         do_frame(1, 0, 1);
         nvec++;
         if (ofs[1] !== 8'(tbl[k])) begin
            errs++;
            $display("FAIL div3 frame%0d: got %0d want %0d", k + 1, ofs[1], tbl[k]);
         end
      end
   endtask

   task automatic test_idle_freeze();
      int tbl[4] = '{7, 9, 12, 16};
      do_reset();
      repeat (3) do_frame(0, 1, 1);
      repeat (4) do_frame(1, 1, 1);
      nvec++;
      if (ofs[0] !== 8'd6) begin
         errs++;
         $display("FAIL both_held: got %0d want 6", ofs[0]);
      end
      for (int k = 0; k < 3; k++) begin
         do_frame(0, 1, 1);
         nvec++;
         if (ofs[0] !== 8'(tbl[k])) begin
            errs++;
            $display("FAIL after_idle %0d: got %0d want %0d", k, ofs[0], tbl[k]);
         end
      end
      repeat (4) do_frame(0, 1, 0);
      nvec++;
      if (ofs[0] !== 8'd12) begin
         errs++;
         $display("FAIL freeze: got %0d want 12", ofs[0]);
      end
      do_frame(0, 1, 1);
      nvec++;
      if (ofs[0] !== 8'(tbl[3])) begin
         errs++;
         $display("FAIL after_freeze: got %0d want %0d", ofs[0], tbl[3]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (11) do_frame(0, 1, 1);
      do_reset();
      do_frame(0, 1, 1);
      nvec++;
      if (ofs[0] !== 8'd1) begin
         errs++;
         $display("FAIL post_reset_step: got %0d want 1", ofs[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 120; k++) begin
         if ($urandom_range(0, 29) == 0) do_reset();
         do_frame(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
      end
   endtask

   initial begin
      rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; scroll_en = 1'b1;
      vif.vblnk = 1'b0; vif.hblnk = 1'b0; vif.vsync = 1'b0; vif.hsync = 1'b0;
      vif.vcount = '0; vif.hcount = '0;
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_step_seq();
      test_right_edge();
      test_div3();
      test_idle_freeze();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
